// File: rtl/cluster_clock_gate_ctrl.sv
// Cluster clock-gate controller.
// Watches cluster activity and, after IDLE_CYCLES consecutive idle cycles, asks the
// cluster to quiesce. Once the cluster acknowledges, the downstream ICG enable is
// dropped. A wake request, renewed activity or disabling gating brings the clock
// back, followed by a fixed settle window of WAKE_CYCLES before wake_ready_o pulses.
//
// Ports:
//   clk_i        free-running ungated clock
//   rst_i        synchronous active-high reset
//   cg_enable_i  gating enable; 0 keeps the clock running
//   busy_i       cluster activity, 1 = not idle
//   wake_req_i   external wake request
//   sleep_ack_i  cluster is quiescent and may be gated
//   stat_clr_i   clears the gated-cycle statistic
//   clk_en_o     registered ICG enable
//   sleep_req_o  quiesce request to the cluster
//   gated_o      1 while gated
//   wake_ready_o one-cycle pulse at the end of the wake settle window
//   gated_cnt_o  saturating count of cycles spent gated
module cluster_clock_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned STAT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cg_enable_i,
  input  logic                  busy_i,
  input  logic                  wake_req_i,
  input  logic                  sleep_ack_i,
  input  logic                  stat_clr_i,
  output logic                  clk_en_o,
  output logic                  sleep_req_o,
  output logic                  gated_o,
  output logic                  wake_ready_o,
  output logic [STAT_WIDTH-1:0] gated_cnt_o
);

  localparam logic [7:0] IdleLimit = 8'(IDLE_CYCLES);
  localparam logic [3:0] WakeLimit = 4'(WAKE_CYCLES);
  localparam logic [STAT_WIDTH-1:0] StatOne = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StRun,
    StCount,
    StReq,
    StGated,
    StWake
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      idle_cnt_q, idle_cnt_d;
  logic [3:0]      wake_cnt_q, wake_cnt_d;
  logic            wake_done;
  logic            abort;

  logic            clk_en_q;
  logic            sleep_req_q;
  logic            gated_q;
  logic            wake_ready_q;
  logic [STAT_WIDTH-1:0] gated_cnt_q;

  // Any of these means the cluster must (keep) running.
  assign abort = busy_i | wake_req_i | ~cg_enable_i;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    wake_done  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!abort) begin
          state_d    = StCount;
          idle_cnt_d = 8'd1;
        end
      end
      StCount: begin
        if (abort) begin
          state_d    = StRun;
          idle_cnt_d = 8'd0;
        end else if (idle_cnt_q == IdleLimit) begin
          state_d    = StReq;
          idle_cnt_d = 8'd0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      StReq: begin
        // Abort wins over a simultaneous acknowledge.
        if (abort) begin
          state_d = StRun;
        end else if (sleep_ack_i) begin
          state_d = StGated;
        end
      end
      StGated: begin
        if (abort) begin
          state_d    = StWake;
          wake_cnt_d = 4'd1;
        end
      end
      StWake: begin
        // Settle window is fixed; inputs are deliberately ignored here.
        if (wake_cnt_q == WakeLimit) begin
          state_d    = StRun;
          wake_cnt_d = 4'd0;
          wake_done  = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d    = StRun;
        idle_cnt_d = 8'd0;
        wake_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StRun;
      idle_cnt_q   <= 8'd0;
      wake_cnt_q   <= 4'd0;
      clk_en_q     <= 1'b1;
      sleep_req_q  <= 1'b0;
      gated_q      <= 1'b0;
      wake_ready_q <= 1'b0;
      gated_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wake_cnt_q   <= wake_cnt_d;
      // Outputs decoded from the next state so they change with the state itself.
      clk_en_q     <= (state_d != StGated);
      sleep_req_q  <= (state_d == StReq);
      gated_q      <= (state_d == StGated);
      wake_ready_q <= wake_done;
      if (stat_clr_i) begin
        gated_cnt_q <= '0;
      end else if ((state_q == StGated) && (gated_cnt_q != '1)) begin
        gated_cnt_q <= gated_cnt_q + StatOne;
      end
    end
  end

  assign clk_en_o     = clk_en_q;
  assign sleep_req_o  = sleep_req_q;
  assign gated_o      = gated_q;
  assign wake_ready_o = wake_ready_q;
  assign gated_cnt_o  = gated_cnt_q;

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Self-checking bench for cluster_clock_gate_ctrl: directed scenarios with constant
// expectations followed by randomized traffic, all checked every cycle against a
// phase/streak reference model.
module tb_cluster_clock_gate_ctrl;

  localparam int unsigned IdleCycles = 16;
  localparam int unsigned WakeCycles = 2;
  localparam int unsigned StatWidth  = 4;
  localparam int          SatMax     = (1 << StatWidth) - 1;

  localparam int PhAwake = 0;
  localparam int PhReq   = 1;
  localparam int PhGated = 2;
  localparam int PhWake  = 3;

  logic clk = 1'b0;
  logic rst, cg_enable, busy, wake_req, sleep_ack, stat_clr;
  logic clk_en, sleep_req, gated, wake_ready;
  logic [StatWidth-1:0] gated_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int m_phase;
  int m_streak;
  int m_settle;
  int m_gcnt;
  bit m_ready;

  cluster_clock_gate_ctrl #(
    .IDLE_CYCLES(IdleCycles),
    .WAKE_CYCLES(WakeCycles),
    .STAT_WIDTH (StatWidth)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cg_enable_i (cg_enable),
    .busy_i      (busy),
    .wake_req_i  (wake_req),
    .sleep_ack_i (sleep_ack),
    .stat_clr_i  (stat_clr),
    .clk_en_o    (clk_en),
    .sleep_req_o (sleep_req),
    .gated_o     (gated),
    .wake_ready_o(wake_ready),
    .gated_cnt_o (gated_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sleep is requested once IdleCycles+1 consecutive idle samples have been seen
  // while awake (the first one leaves RUN, the last one passes the threshold).
  task automatic model_step(input bit r, input bit en, input bit b, input bit w,
                            input bit a, input bit c);
    bit ab;
    ab = b || w || !en;
    m_ready = 1'b0;
    if (r) begin
      m_phase  = PhAwake;
      m_streak = 0;
      m_settle = 0;
      m_gcnt   = 0;
    end else begin
      if (c) m_gcnt = 0;
      else if (m_phase == PhGated) m_gcnt = (m_gcnt < SatMax) ? m_gcnt + 1 : SatMax;
      case (m_phase)
        PhAwake: begin
          m_streak = ab ? 0 : m_streak + 1;
          if (m_streak == IdleCycles + 1) begin
            m_phase  = PhReq;
            m_streak = 0;
          end
        end
        PhReq: begin
          if (ab) m_phase = PhAwake;
          else if (a) m_phase = PhGated;
        end
        PhGated: begin
          if (ab) begin
            m_phase  = PhWake;
            m_settle = WakeCycles;
          end
        end
        default: begin
          m_settle--;
          if (m_settle == 0) begin
            m_phase = PhAwake;
            m_ready = 1'b1;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit r, input bit en, input bit b, input bit w,
                      input bit a, input bit c);
    rst = r; cg_enable = en; busy = b; wake_req = w; sleep_ack = a; stat_clr = c;
    @(posedge clk);
    #1;
    model_step(r, en, b, w, a, c);
    check_eq("model_flags", {28'd0, clk_en, sleep_req, gated, wake_ready},
             {28'd0, m_phase != PhGated, m_phase == PhReq, m_phase == PhGated, m_ready});
    check_eq("model_gcnt", 32'(gated_cnt), 32'(m_gcnt));
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 0, 0);
  endtask

  task automatic go_gated();
    int k;
    k = 0;
    while (!sleep_req && k < 40) begin
      idle();
      k++;
    end
    check_eq("reach_req", 32'(sleep_req), 32'd1);
    step(0, 1, 0, 0, 1, 0);
    check_eq("reach_gated", 32'(gated), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int quiet;
    rst = 1'b1; cg_enable = 1'b0; busy = 1'b0; wake_req = 1'b0;
    sleep_ack = 1'b0; stat_clr = 1'b0;

    // Reset values.
    step(1, 0, 0, 0, 0, 0);
    check_eq("rst_clk_en", 32'(clk_en), 32'd1);
    check_eq("rst_sleep_req", 32'(sleep_req), 32'd0);
    check_eq("rst_gated", 32'(gated), 32'd0);
    check_eq("rst_wake_ready", 32'(wake_ready), 32'd0);
    check_eq("rst_gcnt", 32'(gated_cnt), 32'd0);

    // Idle threshold and gating.
    for (int k = 0; k <= 16; k++) begin
      idle();
      if (k == 15) check_eq("sleep_req_early", 32'(sleep_req), 32'd0);
      if (k == 16) check_eq("sleep_req_rise", 32'(sleep_req), 32'd1);
    end
    step(0, 1, 0, 0, 1, 0);
    check_eq("gate_clk_en", 32'(clk_en), 32'd0);
    check_eq("gate_gated", 32'(gated), 32'd1);

    // Ten gated cycles then wake.
    for (int k = 0; k < 9; k++) idle();
    step(0, 1, 0, 1, 0, 0);
    check_eq("wake_clk_en", 32'(clk_en), 32'd1);
    check_eq("wake_gcnt", 32'(gated_cnt), 32'd10);
    idle();
    check_eq("wake_ready_1", 32'(wake_ready), 32'd0);
    idle();
    check_eq("wake_ready_2", 32'(wake_ready), 32'd1);
    idle();
    check_eq("wake_ready_3", 32'(wake_ready), 32'd0);

    // Saturation of the gated counter, then clear beating an increment.
    step(0, 1, 0, 0, 0, 1);
    check_eq("clr_gcnt", 32'(gated_cnt), 32'd0);
    go_gated();
    for (int k = 0; k < 14; k++) idle();
    check_eq("sat_pre", 32'(gated_cnt), 32'd14);
    for (int k = 0; k < 5; k++) idle();
    check_eq("sat_hold", 32'(gated_cnt), 32'd15);
    step(0, 1, 0, 0, 0, 1);
    check_eq("sat_clr", 32'(gated_cnt), 32'd0);
    step(0, 1, 0, 1, 0, 0);
    idle();
    idle();

    // Abort beats acknowledge in REQ.
    while (!sleep_req && n_cmp < 100000) idle();
    step(0, 1, 0, 1, 1, 0);
    check_eq("abort_clk_en", 32'(clk_en), 32'd1);
    check_eq("abort_sleep_req", 32'(sleep_req), 32'd0);
    check_eq("abort_gated", 32'(gated), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 0, 1, 0);
      check_eq("abort_no_gate", 32'(gated), 32'd0);
    end

    // Busy on idle cycle 15 restarts the full count.
    for (int k = 0; k < 15; k++) idle();
    step(0, 1, 1, 0, 0, 0);
    check_eq("busy15_no_req", 32'(sleep_req), 32'd0);
    for (int k = 0; k <= 16; k++) begin
      idle();
      if (k == 15) check_eq("recount_early", 32'(sleep_req), 32'd0);
      if (k == 16) check_eq("recount_rise", 32'(sleep_req), 32'd1);
    end
    step(0, 1, 1, 0, 0, 0);

    // Reset mid-gated, then gating disabled.
    go_gated();
    for (int k = 0; k < 3; k++) idle();
    step(1, 1, 0, 0, 0, 0);
    check_eq("rstg_clk_en", 32'(clk_en), 32'd1);
    check_eq("rstg_gated", 32'(gated), 32'd0);
    for (int k = 0; k < 100; k++) begin
      step(0, 0, 0, 0, k[0], 0);
      check_eq("disabled_clk_en", 32'(clk_en), 32'd1);
    end

    // Randomized traffic with quiet stretches so gating actually happens.
    quiet = 0;
    for (int i = 0; i < 3000; i++) begin
      if (quiet > 0) begin
        quiet--;
        step($urandom_range(0, 299) == 0, 1, 0, 0, $urandom_range(0, 1),
             $urandom_range(0, 49) == 0);
      end else begin
        if ($urandom_range(0, 9) == 0) quiet = $urandom_range(10, 40);
        step($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 1), $urandom_range(0, 49) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cluster_clock_gate_ctrl.md
CLUSTER_CLOCK_GATE_CTRL -- requirements
Module: cluster_clock_gate_ctrl

Interface
REQ-001 SHALL: parameter IDLE_CYCLES, default 16, number of consecutive idle cycles before a sleep request (legal range 1..255).
REQ-002 SHALL: parameter WAKE_CYCLES, default 2, number of cycles the clock runs before wake_ready_o asserts (legal range 1..15).
REQ-003 SHALL: parameter STAT_WIDTH, default 32, width of the gated-cycle statistic counter.
REQ-004 SHALL: clk_i  input  1  free-running, ungated clock; the block runs on it.
REQ-005 SHALL: rst_i  input  1  reset; synchronous, active-high.
REQ-006 SHALL: cg_enable_i  input  1  configuration enable for clock gating; 0 keeps the clock running.
REQ-007 SHALL: busy_i  input  1  cluster activity indication; 1 means not idle.
REQ-008 SHALL: wake_req_i  input  1  external wake request (interrupt or event).
REQ-009 SHALL: sleep_ack_i  input  1  cluster acknowledges that it is quiescent and may be gated.
REQ-010 SHALL: stat_clr_i  input  1  clears the gated-cycle counter.
REQ-011 SHALL: clk_en_o  output  1  registered enable driving the downstream ICG enable input.
REQ-012 SHALL: sleep_req_o  output  1  request to the cluster to quiesce.
REQ-013 SHALL: gated_o  output  1  status flag; 1 while the state is GATED.
REQ-014 SHALL: wake_ready_o  output  1  single-cycle pulse when the wake settle time ends.
REQ-015 SHALL: gated_cnt_o  output  STAT_WIDTH  number of cycles spent in GATED.

Function
REQ-016 SHALL: state machine states are RUN, COUNT, REQ, GATED and WAKE.
REQ-017 SHALL: all outputs are registered and decoded from the next state, so each output changes on the clock edge that enters the new state.
REQ-018 SHALL: clk_en_o is 1 in RUN, COUNT, REQ and WAKE, and 0 only in GATED.
REQ-019 SHALL: sleep_req_o is 1 only in REQ; gated_o is 1 only in GATED.
REQ-020 SHALL: RUN->COUNT when cg_enable_i=1, busy_i=0 and wake_req_i=0; the idle counter loads 1 on this transition.
REQ-021 SHALL: COUNT->RUN when busy_i=1, wake_req_i=1 or cg_enable_i=0; the idle counter clears.
REQ-022 SHALL: in COUNT the idle counter increments each idle cycle; COUNT->REQ on the cycle the counter equals IDLE_CYCLES.
- Net effect: sleep_req_o rises IDLE_CYCLES cycles after the first idle cycle is sampled.
REQ-023 SHALL: REQ->RUN (abort) when busy_i=1, wake_req_i=1 or cg_enable_i=0; abort has priority over sleep_ack_i sampled in the same cycle.
REQ-024 SHALL: REQ->GATED when sleep_ack_i=1 and no abort condition is present; sleep_ack_i is ignored in every other state.
REQ-025 SHALL: GATED->WAKE when wake_req_i=1, busy_i=1 or cg_enable_i=0; clk_en_o returns to 1 on the edge entering WAKE.
REQ-026 SHALL: in WAKE a settle counter runs from 1 to WAKE_CYCLES; on reaching WAKE_CYCLES the state goes WAKE->RUN and wake_ready_o pulses high for exactly that one cycle.
REQ-027 SHALL: wake_req_i, busy_i and cg_enable_i changes during WAKE do not shorten or extend the settle time.
REQ-028 SHALL: gated_cnt_o increments by 1 each cycle the current state is GATED and saturates at all-ones (no wrap).
REQ-029 SHALL: stat_clr_i=1 sets gated_cnt_o to 0 on the next edge; clear has priority over an increment in the same cycle.
REQ-030 SHALL: with cg_enable_i=0 the block never leaves RUN except to finish an in-progress WAKE, so clk_en_o stays 1.
REQ-031 SHALL: clk_en_o is glitch-free, being a flop output of the clk_i domain.

Reset
REQ-032 SHALL: when rst_i=1 is sampled, the state goes to RUN and both internal counters clear.
REQ-033 SHALL: on that same reset edge, clk_en_o=1, sleep_req_o=0, gated_o=0, wake_ready_o=0 and gated_cnt_o=0.
REQ-034 SHALL: reset asserted while in GATED or REQ re-enables the clock (clk_en_o=1) on the reset edge, without passing through WAKE.

Verification
REQ-035 SHALL: reset, then cg_enable_i=1, busy_i=0 held -> sleep_req_o rises 16 cycles after the first idle sample; sleep_ack_i=1 -> clk_en_o=0 and gated_o=1 on the next edge.
REQ-036 SHALL: in GATED for 10 cycles, pulse wake_req_i -> clk_en_o=1 on the next edge, wake_ready_o pulses 2 cycles later, and gated_cnt_o=10.
REQ-037 SHALL: in REQ, assert sleep_ack_i and wake_req_i together -> state RUN, clk_en_o stays 1 and gated_o never asserts.
REQ-038 SHALL: busy_i pulses on idle cycle 15 -> no sleep_req_o; a full new 16-cycle idle count is required before sleep_req_o rises.
REQ-039 SHALL: gated_cnt_o preloaded near saturation (STAT_WIDTH=4, 14 gated cycles), then 5 more gated cycles -> gated_cnt_o=15 held; stat_clr_i -> 0.
REQ-040 SHALL: rst_i asserted mid-GATED -> clk_en_o=1 and gated_o=0 on the reset edge; cg_enable_i=0 thereafter -> clk_en_o stays 1 for 100 idle cycles.
